ar_tag_allocator: RTL and testbench

//  Consumes AR requests from the incoming request buffer and assigns each a free internal tag.

---
 rtl/ar_tag_allocator_if.sv | 50 +++++
 rtl/ar_tag_allocator.sv | 120 ++++++++++++
 tb/tb_ar_tag_allocator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_tag_allocator_if.sv
// AR request, downstream AR and tag-release signals of the tag allocator.
// Latency: none (signal bundle only).
// Backpressure: valid/ready on both AR sides; release has no backpressure.
interface ar_tag_allocator_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
) ();
  // upstream AR
  logic                  in_valid;
  logic                  in_ready;
  logic [ID_WIDTH-1:0]   in_id;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [LEN_WIDTH-1:0]  in_len;
  logic [2:0]            in_size;
  logic [1:0]            in_burst;
  logic [3:0]            in_qos;
  // downstream AR, id replaced by tag
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [LEN_WIDTH-1:0]  out_len;
  logic [2:0]            out_size;
  logic [1:0]            out_burst;
  logic [3:0]            out_qos;
  // tag release from the R return path
  logic                  rel_valid;
  logic [TAG_WIDTH-1:0]  rel_tag;
  logic [ID_WIDTH-1:0]   rel_orig_id;

  modport slave (
    input  in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos,
    output in_ready,
    output out_valid, out_tag, out_addr, out_len, out_size, out_burst, out_qos,
    input  out_ready,
    input  rel_valid, rel_tag,
    output rel_orig_id
  );

  modport master (
    output in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos,
    input  in_ready,
    input  out_valid, out_tag, out_addr, out_len, out_size, out_burst, out_qos,
    output out_ready,
    output rel_valid, rel_tag,
    input  rel_orig_id
  );
endinterface

// File: rtl/ar_tag_allocator.sv
// Assigns a free internal tag to each AR request and remembers its original ID until release.
// Latency: 1 cycle from input accept to out_valid (single output register stage).
// Backpressure: in_ready drops when all tags are busy or the output register is held by !out_ready.
module ar_tag_allocator #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ar_tag_allocator_if.slave    bus,
  output logic [TAG_WIDTH:0]   outstanding,
  output logic                 full,
  output logic                 err_bad_free
);
  localparam int NUM_TAGS = 1 << TAG_WIDTH;

  // AR fields carried through unchanged
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
  } ar_hdr_t;

  logic [NUM_TAGS-1:0] busy;
  logic [ID_WIDTH-1:0] id_tbl [NUM_TAGS];
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic                 out_valid_q;
  logic [TAG_WIDTH:0]   outstanding_q;
  logic                 err_q;
  ar_hdr_t              in_hdr;
  ar_hdr_t              out_hdr;
  logic                 accept;
  logic                 rel_ok;

  assign in_hdr = '{addr: bus.in_addr, len: bus.in_len, size: bus.in_size,
                    burst: bus.in_burst, qos: bus.in_qos};

  // Allocation uses only the registered busy vector, so a tag freed this
  // cycle is not reusable until the next one, even when full.
  assign full         = &busy;
  assign bus.in_ready = !full && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign rel_ok       = bus.rel_valid && busy[bus.rel_tag];

  assign bus.rel_orig_id = id_tbl[bus.rel_tag];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_addr    = out_hdr.addr;
  assign bus.out_len     = out_hdr.len;
  assign bus.out_size    = out_hdr.size;
  assign bus.out_burst   = out_hdr.burst;
  assign bus.out_qos     = out_hdr.qos;
  assign outstanding     = outstanding_q;
  assign err_bad_free    = err_q;

  // Lowest-index free tag: scan downwards so the lowest free index wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = TAG_WIDTH'(i);
    end
  end

  // Busy vector: release clears, accept sets; an accepted tag is never the released one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (rel_ok) busy[bus.rel_tag] <= 1'b0;
      if (accept) busy[alloc_tag]   <= 1'b1;
    end
  end

  // Original ID table; contents only meaningful while the tag is busy.
  always_ff @(posedge clk) begin
    if (accept) id_tbl[alloc_tag] <= bus.in_id;
  end

  // Output register: load on accept, drop on handshake, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_hdr     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_tag_q   <= alloc_tag;
      out_hdr     <= in_hdr;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Busy-tag count; simultaneous accept and valid release cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, rel_ok})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Sticky flag for releasing a tag that was not allocated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.rel_valid && !busy[bus.rel_tag]) begin
      err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ar_tag_allocator.sv
// Self-checking bench for ar_tag_allocator: vector table plus directed corner sequences.
// Latency: checks registered outputs 1 ns after each rising edge.
// Backpressure: out_ready driven per cycle from the stimulus.
module tb_ar_tag_allocator;
  logic       clk;
  logic       rst;
  logic [4:0] outstanding;
  logic       full;
  logic       err_bad_free;

  ar_tag_allocator_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .TAG_WIDTH(4)) bus ();

  ar_tag_allocator #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .TAG_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .outstanding  (outstanding),
    .full         (full),
    .err_bad_free (err_bad_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model
  bit [15:0]  m_busy;
  logic [3:0] m_id [16];
  int         m_out;
  bit         m_ov;
  bit         m_err;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  qos;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          iv;
    logic [3:0]  id;
    logic [31:0] addr;
    bit          ordy;
    bit          rv;
    logic [3:0]  rt;
    bit          exp_rdy;
    int          exp_out;
    bit          exp_err;
  } vec_t;
  vec_t tv [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_out  = 0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input bit iv, input logic [3:0] id, input logic [31:0] addr,
                     input bit ordy, input bit rv, input logic [3:0] rt, output bit rdy_seen);
    bit   m_rdy;
    bit   acc;
    int   ft;
    exp_t e;
    bus.in_valid  = iv;
    bus.in_id     = id;
    bus.in_addr   = addr;
    bus.in_len    = addr[7:0];
    bus.in_size   = 3'd2;
    bus.in_burst  = 2'd1;
    bus.in_qos    = id;
    bus.out_ready = ordy;
    bus.rel_valid = rv;
    bus.rel_tag   = rt;
    #1;
    m_rdy = !(&m_busy) && (!m_ov || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
    rdy_seen = bus.in_ready;
    if (rv && m_busy[rt]) chk("rel_orig_id", 64'(bus.rel_orig_id), 64'(m_id[rt]));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_output: got tag %0h expected no output", bus.out_tag);
      end else begin
        chk("out_tag",  64'(bus.out_tag),  64'(sb[0].tag));
        chk("out_addr", 64'(bus.out_addr), 64'(sb[0].addr));
        chk("out_len",  64'(bus.out_len),  64'(sb[0].len));
        chk("out_qos",  64'(bus.out_qos),  64'(sb[0].qos));
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = iv && m_rdy;
    ft  = 0;
    for (int i = 15; i >= 0; i--) if (!m_busy[i]) ft = i;
    if (acc) begin
      e.tag  = 4'(ft);
      e.addr = addr;
      e.len  = addr[7:0];
      e.qos  = id;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rv) begin
      if (m_busy[rt]) begin
        m_busy[rt] = 1'b0;
        m_out--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (acc) begin
      m_busy[ft] = 1'b1;
      m_id[ft]   = id;
      m_out++;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("outstanding",  64'(outstanding),  64'(m_out));
    chk("full",         64'(full),         64'(&m_busy));
    chk("err_bad_free", 64'(err_bad_free), 64'(m_err));
  endtask

  // Asynchronous reset asserted mid-cycle; effects checked before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding),   64'd0);
    chk("rst_full",        64'(full),          64'd0);
    chk("rst_err",         64'(err_bad_free),  64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit r;
    tv[0] = '{iv: 1, id: 4'd5, addr: 32'h100, ordy: 1, rv: 0, rt: 4'd0, exp_rdy: 1, exp_out: 1, exp_err: 0};
    tv[1] = '{iv: 1, id: 4'd9, addr: 32'h104, ordy: 1, rv: 0, rt: 4'd0, exp_rdy: 1, exp_out: 2, exp_err: 0};
    tv[2] = '{iv: 1, id: 4'd5, addr: 32'h108, ordy: 1, rv: 0, rt: 4'd0, exp_rdy: 1, exp_out: 3, exp_err: 0};
    tv[3] = '{iv: 0, id: 4'd0, addr: 32'h0,   ordy: 1, rv: 1, rt: 4'd4, exp_rdy: 1, exp_out: 3, exp_err: 1};
    tv[4] = '{iv: 0, id: 4'd0, addr: 32'h0,   ordy: 1, rv: 0, rt: 4'd0, exp_rdy: 1, exp_out: 3, exp_err: 1};

    rst = 1'b1;
    bus.in_valid = 0; bus.in_id = 0; bus.in_addr = 0; bus.in_len = 0;
    bus.in_size = 0; bus.in_burst = 0; bus.in_qos = 0;
    bus.out_ready = 0; bus.rel_valid = 0; bus.rel_tag = 0;
    model_reset();
    #3;
    chk("reset_out_valid",   64'(bus.out_valid), 64'd0);
    chk("reset_out_tag",     64'(bus.out_tag),   64'd0);
    chk("reset_out_addr",    64'(bus.out_addr),  64'd0);
    chk("reset_outstanding", 64'(outstanding),   64'd0);
    chk("reset_full",        64'(full),          64'd0);
    chk("reset_err",         64'(err_bad_free),  64'd0);
    chk("reset_in_ready",    64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // three requests, then a release of idle tag 4
    for (int i = 0; i < 5; i++) begin
      cyc(tv[i].iv, tv[i].id, tv[i].addr, tv[i].ordy, tv[i].rv, tv[i].rt, r);
      chk($sformatf("vec%0d_in_ready", i),    64'(r),            64'(tv[i].exp_rdy));
      chk($sformatf("vec%0d_outstanding", i), 64'(outstanding),  64'(tv[i].exp_out));
      chk($sformatf("vec%0d_err", i),         64'(err_bad_free), 64'(tv[i].exp_err));
    end

    // fill remaining tags 3..15 (id equals tag)
    for (int i = 0; i < 13; i++) cyc(1, 4'(3 + i), 32'h200 + 32'(4 * i), 1, 0, 4'd0, r);
    chk("fill_full", 64'(full), 64'd1);
    cyc(0, 4'd0, 32'h0, 1, 0, 4'd0, r);
    chk("fill_in_ready", 64'(r), 64'd0);

    // release tag 7 while full with a request pending: no accept that cycle
    cyc(1, 4'hA, 32'h300, 1, 1, 4'd7, r);
    chk("rel7_in_ready", 64'(r), 64'd0);
    chk("rel7_outstanding", 64'(outstanding), 64'd15);
    cyc(1, 4'hC, 32'h304, 1, 0, 4'd0, r);
    chk("realloc7_in_ready", 64'(r), 64'd1);
    chk("realloc7_tag", 64'(bus.out_tag), 64'd7);
    chk("realloc7_outstanding", 64'(outstanding), 64'd16);

    // same with tag 3
    cyc(1, 4'hD, 32'h400, 1, 1, 4'd3, r);
    chk("rel3_in_ready", 64'(r), 64'd0);
    chk("rel3_outstanding", 64'(outstanding), 64'd15);
    cyc(1, 4'hD, 32'h400, 1, 0, 4'd0, r);
    chk("realloc3_tag", 64'(bus.out_tag), 64'd3);
    chk("realloc3_outstanding", 64'(outstanding), 64'd16);

    // downstream stall holds the output and blocks input
    cyc(0, 4'd0, 32'h0, 1, 1, 4'd0, r);
    cyc(0, 4'd0, 32'h0, 1, 1, 4'd1, r);
    cyc(1, 4'h2, 32'h500, 0, 0, 4'd0, r);
    chk("stall_first_accept", 64'(r), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'h3, 32'h504, 0, 0, 4'd0, r);
      chk("stall_in_ready", 64'(r), 64'd0);
      chk("stall_out_tag", 64'(bus.out_tag), 64'd0);
      chk("stall_out_addr", 64'(bus.out_addr), 64'h500);
    end
    cyc(1, 4'h3, 32'h504, 1, 0, 4'd0, r);
    chk("unstall_in_ready", 64'(r), 64'd1);
    chk("unstall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("unstall_out_tag", 64'(bus.out_tag), 64'd1);
    cyc(0, 4'd0, 32'h0, 1, 0, 4'd0, r);

    // reset clears the sticky error; then reset with 5 busy and output pending
    async_reset();
    for (int i = 0; i < 5; i++) cyc(1, 4'(i), 32'h600 + 32'(4 * i), 1, 0, 4'd0, r);
    chk("pre_rst_outstanding", 64'(outstanding), 64'd5);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    async_reset();
    cyc(1, 4'h6, 32'h700, 1, 0, 4'd0, r);
    chk("post_rst_tag", 64'(bus.out_tag), 64'd0);
    chk("post_rst_outstanding", 64'(outstanding), 64'd1);
    cyc(0, 4'd0, 32'h0, 1, 0, 4'd0, r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
